adder_32_ctrl: RTL and testbench

- Sequencer for the 32-input pipelined adder tree (12-bit Q7.5 operands).
- Accepts a job of NUM_GROUPS vectors, each 32 x DATA_WIDTH. Streams them into the adder through a valid/ready input port.
- Counts the adder's returned partial sums and accumulates them into a wide signed accumulator.
- Presents one saturated DATA_WIDTH result per job on a valid/ready output port. Supports abort, which flushes the adder through its end_flag.

---
 rtl/adder_32_ctrl.sv | 145 ++++++++++++++
 tb/tb_adder_32_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_32_ctrl.sv
// Job sequencer for the 32-input pipelined adder tree: streams NUM_GROUPS vectors in,
// accumulates the returned partial sums and presents one saturated result per job.
module adder_32_ctrl #(
  parameter int DATA_WIDTH = 12,
  parameter int NUM_INPUTS = 32,
  parameter int GW         = 8,
  parameter int ACC_WIDTH  = 22
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [GW-1:0]                    num_groups,
  input  logic                             abort,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  output logic                             adder_valid_in,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] adder_data,
  output logic                             adder_end_flag,
  input  logic                             adder_valid_out,
  input  logic [DATA_WIDTH-1:0]            adder_sum,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             busy,
  output logic                             cfg_err
);

  typedef enum logic [2:0] {S_IDLE, S_FEED, S_DRAIN, S_OUT, S_FLUSH} state_e;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (DATA_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  state_e                             state_q, state_d;
  logic [GW-1:0]                      num_q, num_d;
  logic [GW-1:0]                      issue_cnt_q, issue_cnt_d;
  logic [GW-1:0]                      ret_cnt_q, ret_cnt_d;
  logic signed [ACC_WIDTH-1:0]        acc_q, acc_d;
  logic                               avin_q, avin_d;
  logic [NUM_INPUTS*DATA_WIDTH-1:0]   adata_q, adata_d;
  logic [DATA_WIDTH-1:0]              odata_q, odata_d;
  logic                               cfg_err_q, cfg_err_d;
  logic                               xfer, ret, active;

  function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] a);
    if (a > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
    else if (a < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    return a[DATA_WIDTH-1:0];
  endfunction

  assign in_ready       = (state_q == S_FEED) && (issue_cnt_q < num_q);
  assign out_valid      = (state_q == S_OUT);
  assign busy           = (state_q != S_IDLE);
  assign adder_end_flag = (state_q == S_FLUSH);
  assign adder_valid_in = avin_q;
  assign adder_data     = adata_q;
  assign out_data       = odata_q;
  assign cfg_err        = cfg_err_q;

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    acc_d       = acc_q;
    avin_d      = 1'b0;
    adata_d     = adata_q;
    odata_d     = odata_q;
    cfg_err_d   = 1'b0;
    xfer        = in_valid && in_ready;
    ret         = adder_valid_out && ((state_q == S_FEED) || (state_q == S_DRAIN));
    active      = (state_q == S_FEED) || (state_q == S_DRAIN) || (state_q == S_OUT);

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (num_groups == '0) begin
            cfg_err_d = 1'b1;
          end else begin
            num_d       = num_groups;
            issue_cnt_d = '0;
            ret_cnt_d   = '0;
            acc_d       = '0;
            state_d     = S_FEED;
          end
        end
      end
      S_FEED, S_DRAIN: begin
        if (xfer) begin
          adata_d     = in_data;
          avin_d      = 1'b1;
          issue_cnt_d = issue_cnt_q + GW'(1);
          if (issue_cnt_d == num_q) state_d = S_DRAIN;
        end
        // The final return wins over the FEED->DRAIN move; result is captured on OUT entry.
        if (ret) begin
          acc_d     = acc_q + {{(ACC_WIDTH-DATA_WIDTH){adder_sum[DATA_WIDTH-1]}}, adder_sum};
          ret_cnt_d = ret_cnt_q + GW'(1);
          if (ret_cnt_d == num_q) begin
            state_d = S_OUT;
            odata_d = sat(acc_d);
          end
        end
      end
      S_OUT:   if (out_ready) state_d = S_IDLE;
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && active) begin
      state_d     = S_FLUSH;
      issue_cnt_d = '0;
      ret_cnt_d   = '0;
      acc_d       = '0;
      avin_d      = 1'b0;
      adata_d     = adata_q;
      odata_d     = odata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      acc_q       <= '0;
      avin_q      <= 1'b0;
      adata_q     <= '0;
      odata_q     <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      acc_q       <= acc_d;
      avin_q      <= avin_d;
      adata_q     <= adata_d;
      odata_q     <= odata_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_adder_32_ctrl.sv
// Directed bench for adder_32_ctrl with a 3-cycle behavioural adder tree model.
module tb_adder_32_ctrl;
  localparam int DW = 12;
  localparam int NI = 32;
  localparam int GW = 8;

  logic              clk, reset, start, abort, in_valid, in_ready;
  logic [GW-1:0]     num_groups;
  logic [NI*DW-1:0]  in_data, adder_data;
  logic              adder_valid_in, adder_end_flag, adder_valid_out;
  logic [DW-1:0]     adder_sum, out_data;
  logic              out_valid, out_ready, busy, cfg_err;

  adder_32_ctrl #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .GW(GW), .ACC_WIDTH(22)) dut (
    .clk(clk), .reset(reset), .start(start), .num_groups(num_groups), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .adder_valid_in(adder_valid_in), .adder_data(adder_data), .adder_end_flag(adder_end_flag),
    .adder_valid_out(adder_valid_out), .adder_sum(adder_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder model: output scaling is a property of the adder, so it is selectable per test;
  // force_en replaces the sum with a fixed value. end_flag deliberately does not flush it,
  // so outstanding results still arrive after an abort.
  int unsigned       adder_shift;
  bit                force_en;
  logic [DW-1:0]     force_val;
  logic [2:0]        pv;
  logic [2:0][DW-1:0] ps;

  function automatic logic [DW-1:0] tree(input logic [NI*DW-1:0] d);
    int s;
    s = 0;
    for (int i = 0; i < NI; i++) s += int'($signed(d[i*DW +: DW]));
    s = s >>> adder_shift;
    return s[DW-1:0];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      pv <= '0;
      ps <= '0;
    end else begin
      pv <= {pv[1:0], adder_valid_in};
      ps <= {ps[1:0], force_en ? force_val : tree(adder_data)};
    end
  end
  assign adder_valid_out = pv[2];
  assign adder_sum       = ps[2];

  int n_avin, n_xfer, n_ret, n_irdy, n_irise, n_endf;
  logic irdy_prev;
  initial begin
    n_avin = 0; n_xfer = 0; n_ret = 0; n_irdy = 0; n_irise = 0; n_endf = 0; irdy_prev = 1'b0;
  end
  always @(negedge clk) begin
    n_avin    <= n_avin + (adder_valid_in ? 1 : 0);
    n_xfer    <= n_xfer + ((in_valid && in_ready) ? 1 : 0);
    n_ret     <= n_ret + (adder_valid_out ? 1 : 0);
    n_irdy    <= n_irdy + (in_ready ? 1 : 0);
    n_irise   <= n_irise + ((in_ready && !irdy_prev) ? 1 : 0);
    n_endf    <= n_endf + (adder_end_flag ? 1 : 0);
    irdy_prev <= in_ready;
  end

  int pass_cnt, total_cnt;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic feed_job(input int ng, input logic [DW-1:0] lane, input bit rnd);
    int sent;
    bit go;
    start = 1'b1; num_groups = GW'(ng);
    step();
    start = 1'b0;
    sent = 0;
    for (int c = 0; c < 300 && sent < ng; c++) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = {NI{lane}};
      go = in_valid && in_ready;
      step();
      if (go) sent++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int c;
    for (c = 0; c < 100 && !out_valid; c++) step();
    total_cnt++;
    if (!out_valid) $display("FAIL %s_timeout: out_valid never rose within %0d cycles", name, c);
    else pass_cnt++;
  endtask

  task automatic accept_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    total_cnt++; if ({in_ready, out_valid, busy, adder_valid_in, adder_end_flag, cfg_err} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000", {in_ready, out_valid, busy, adder_valid_in, adder_end_flag, cfg_err}); else pass_cnt++;
    total_cnt++; if (out_data !== 12'h000) $display("FAIL reset_out_data: got %h want 000", out_data); else pass_cnt++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    int a0;
    adder_shift = 0; force_en = 1'b0;
    a0 = n_avin;
    feed_job(1, 12'h020, 1'b0);
    wait_out("single");
    total_cnt++; if (out_data !== 12'h400) $display("FAIL single_out_data: got %h want 400", out_data); else pass_cnt++;
    total_cnt++; if (n_avin - a0 !== 1) $display("FAIL single_avin_pulses: got %0d want 1", n_avin - a0); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++; if (!out_valid || out_data !== 12'h400)
        $display("FAIL single_hold: valid %b data %h want 1/400", out_valid, out_data); else pass_cnt++;
    end
    accept_out();
    total_cnt++; if ({busy, out_valid} !== 2'b00) $display("FAIL single_after_hs: busy/out_valid %b want 00", {busy, out_valid}); else pass_cnt++;
  endtask

  task automatic test_stream();
    int a0, x0, r0, i0, s0;
    adder_shift = 5; force_en = 1'b0;
    a0 = n_avin; x0 = n_xfer; r0 = n_ret; i0 = n_irdy; s0 = n_irise;
    feed_job(4, 12'h001, 1'b0);
    wait_out("stream");
    total_cnt++; if (out_data !== 12'h004) $display("FAIL stream_out_data: got %h want 004", out_data); else pass_cnt++;
    total_cnt++; if (n_irdy - i0 !== 4 || n_irise - s0 !== 1)
      $display("FAIL stream_in_ready: high %0d cycles in %0d runs, want 4 in 1", n_irdy - i0, n_irise - s0); else pass_cnt++;
    total_cnt++; if (n_avin - a0 !== 4 || n_xfer - x0 !== 4 || n_ret - r0 !== 4)
      $display("FAIL stream_counts: avin %0d xfer %0d ret %0d want 4", n_avin - a0, n_xfer - x0, n_ret - r0); else pass_cnt++;
    accept_out();
  endtask

  task automatic test_backpressure();
    int a0, x0, r0, stable;
    adder_shift = 5; force_en = 1'b0;
    a0 = n_avin; x0 = n_xfer; r0 = n_ret;
    feed_job(5, 12'h001, 1'b1);
    wait_out("bp");
    total_cnt++; if (n_xfer - x0 !== 5 || n_avin - a0 !== 5 || n_ret - r0 !== 5)
      $display("FAIL bp_counts: xfer %0d avin %0d ret %0d want 5", n_xfer - x0, n_avin - a0, n_ret - r0); else pass_cnt++;
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid && out_data === 12'h005) stable++;
      step();
    end
    total_cnt++; if (stable !== 10) $display("FAIL bp_stable: got %0d stable cycles want 10", stable); else pass_cnt++;
    accept_out();
    total_cnt++; if (busy !== 1'b0) $display("FAIL bp_idle: busy %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_saturation();
    force_en = 1'b1; force_val = 12'h7FF;
    feed_job(8, 12'h000, 1'b0);
    wait_out("sat_pos");
    total_cnt++; if (out_data !== 12'h7FF) $display("FAIL sat_pos: got %h want 7ff", out_data); else pass_cnt++;
    accept_out();
    force_val = 12'h800;
    feed_job(8, 12'h000, 1'b0);
    wait_out("sat_neg");
    total_cnt++; if (out_data !== 12'h800) $display("FAIL sat_neg: got %h want 800", out_data); else pass_cnt++;
    accept_out();
    force_en = 1'b0;
  endtask

  task automatic test_abort();
    int r0, e0, c, ov;
    adder_shift = 0; force_en = 1'b0;
    r0 = n_ret; e0 = n_endf;
    feed_job(4, 12'h001, 1'b0);
    for (c = 0; c < 50 && (n_ret - r0) < 2; c++) step();
    total_cnt++; if (n_ret - r0 !== 2) $display("FAIL abort_setup: got %0d returns want 2", n_ret - r0); else pass_cnt++;
    abort = 1'b1;
    step();
    abort = 1'b0;
    total_cnt++; if ({adder_end_flag, busy, in_ready, out_valid} !== 4'b1100)
      $display("FAIL abort_flush: end/busy/irdy/ovld %b want 1100", {adder_end_flag, busy, in_ready, out_valid}); else pass_cnt++;
    step();
    total_cnt++; if ({adder_end_flag, busy} !== 2'b00) $display("FAIL abort_idle: end/busy %b want 00", {adder_end_flag, busy}); else pass_cnt++;
    ov = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid || busy) ov++;
      step();
    end
    total_cnt++; if (n_endf - e0 !== 1 || ov !== 0)
      $display("FAIL abort_endflag: end_flag cycles %0d stray %0d want 1/0", n_endf - e0, ov); else pass_cnt++;
    feed_job(1, 12'h020, 1'b0);
    wait_out("abort_next");
    total_cnt++; if (out_data !== 12'h400) $display("FAIL abort_next_job: got %h want 400", out_data); else pass_cnt++;
    accept_out();
  endtask

  task automatic test_cfg_err();
    start = 1'b1; num_groups = '0;
    step();
    start = 1'b0;
    total_cnt++; if ({cfg_err, busy} !== 2'b10) $display("FAIL cfg_err_pulse: cfg_err/busy %b want 10", {cfg_err, busy}); else pass_cnt++;
    step();
    total_cnt++; if ({cfg_err, busy} !== 2'b00) $display("FAIL cfg_err_clear: cfg_err/busy %b want 00", {cfg_err, busy}); else pass_cnt++;
  endtask

  task automatic test_reset_mid_feed();
    adder_shift = 0; force_en = 1'b0;
    start = 1'b1; num_groups = 8'd4;
    step();
    start = 1'b0; in_valid = 1'b1; in_data = {NI{12'h123}};
    step(); step();
    total_cnt++; if ({busy, in_ready, adder_valid_in} !== 3'b111)
      $display("FAIL midfeed_pre: busy/irdy/avin %b want 111", {busy, in_ready, adder_valid_in}); else pass_cnt++;
    reset = 1'b1;
    step();
    in_valid = 1'b0;
    total_cnt++; if ({busy, in_ready, adder_valid_in, out_valid, adder_end_flag, cfg_err} !== 6'b0 || adder_data !== '0 || out_data !== '0)
      $display("FAIL midfeed_reset: ctrl %b data_nz %b out %h want 0", {busy, in_ready, adder_valid_in, out_valid, adder_end_flag, cfg_err},
               adder_data != '0, out_data); else pass_cnt++;
    reset = 1'b0;
    step();
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    reset = 1'b1; start = 1'b0; num_groups = '0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    adder_shift = 0; force_en = 1'b0; force_val = '0;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_saturation();
    test_abort();
    test_cfg_err();
    test_reset_mid_feed();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
